// File: rtl/mram.sv
// mram: true dual-port word RAM with read-first ports and a two-stage
// registered read pipeline on each port. Port A wins a same-address write
// collision. The pipeline registers clear on the synchronous active-low reset;
// the storage array does not.
// Optional build macro: MRAM_INIT_ZERO_EN -- when defined, every array word
// starts at zero. When undefined, the array has no initial value and maps onto
// plain block RAM.
module mram #(
  parameter int RAM_WIDTH          = 512,
  parameter int MAX_POSITIONS_LOG2 = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          active_port_a_wr_en,
  input  logic [MAX_POSITIONS_LOG2-1:0] active_port_a_addr,
  input  logic [RAM_WIDTH-1:0]          active_port_a_wr_data,
  input  logic                          active_port_b_wr_en,
  input  logic [MAX_POSITIONS_LOG2-1:0] active_port_b_addr,
  input  logic [RAM_WIDTH-1:0]          port_b_wr_data,
  output logic [RAM_WIDTH-1:0]          port_a_rd_data,
  output logic [RAM_WIDTH-1:0]          port_b_rd_data
);

  localparam int DEPTH = 2 ** MAX_POSITIONS_LOG2;

`ifdef MRAM_INIT_ZERO_EN
  logic [RAM_WIDTH-1:0] mem [0:DEPTH-1] = '{default: '0};
`else
  logic [RAM_WIDTH-1:0] mem [0:DEPTH-1];
`endif

  // First pipeline stage: the raw array read, sampled on the address edge.
  logic [RAM_WIDTH-1:0] a_rd_reg;
  logic [RAM_WIDTH-1:0] b_rd_reg;

  // Second pipeline stage: the output registers that drive the ports.
  logic [RAM_WIDTH-1:0] a_out_reg;
  logic [RAM_WIDTH-1:0] b_out_reg;

  // Write both ports. Port B is assigned first, so on a shared address the
  // later port A assignment is the one that lands. Writes are blocked while
  // reset is held low.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (active_port_b_wr_en) begin
        mem[active_port_b_addr] <= port_b_wr_data;
      end
      if (active_port_a_wr_en) begin
        mem[active_port_a_addr] <= active_port_a_wr_data;
      end
    end
  end

  // Two-stage read pipeline for both ports. The non-blocking array read gives
  // the contents from before any write on the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_rd_reg  <= '0;
      b_rd_reg  <= '0;
      a_out_reg <= '0;
      b_out_reg <= '0;
    end else begin
      a_rd_reg  <= mem[active_port_a_addr];
      b_rd_reg  <= mem[active_port_b_addr];
      a_out_reg <= a_rd_reg;
      b_out_reg <= b_rd_reg;
    end
  end

  assign port_a_rd_data = a_out_reg;
  assign port_b_rd_data = b_out_reg;

endmodule

// File: tb/tb_mram.sv
// tb_mram: directed test of mram with hand-computed expected values.
// Inputs change 1 time unit after a rising edge. Outputs are sampled at that
// same point, which is after the edge has settled.
module tb_mram;

  localparam int W  = 512;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [W-1:0]  a_wdata;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [W-1:0]  b_wdata;
  logic [W-1:0]  a_rdata;
  logic [W-1:0]  b_rdata;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] p55, paa, px, py, p11, p22, p01, p02, plo, phi;

  mram #(.RAM_WIDTH(W), .MAX_POSITIONS_LOG2(AW)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .active_port_a_wr_en   (a_we),
    .active_port_a_addr    (a_addr),
    .active_port_a_wr_data (a_wdata),
    .active_port_b_wr_en   (b_we),
    .active_port_b_addr    (b_addr),
    .port_b_wr_data        (b_wdata),
    .port_a_rd_data        (a_rdata),
    .port_b_rd_data        (b_rdata)
  );

  always #5 clk = ~clk;

  // Single comparison point: count it and report any mismatch.
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle write on both ports. Write enables drop afterwards.
  task automatic wr(input logic awe, input logic [AW-1:0] aa, input logic [W-1:0] ad,
                    input logic bwe, input logic [AW-1:0] ba, input logic [W-1:0] bd);
    a_we = awe; a_addr = aa; a_wdata = ad;
    b_we = bwe; b_addr = ba; b_wdata = bd;
    tick();
    a_we = 1'b0; b_we = 1'b0;
    $display("write a(en=%0b @%0d) b(en=%0b @%0d)", awe, aa, bwe, ba);
  endtask

  // Present read addresses, wait the two-edge latency, then compare both ports.
  task automatic rd(input string tag, input logic [AW-1:0] aa, input logic [AW-1:0] ba,
                    input logic [W-1:0] ea, input logic [W-1:0] eb);
    a_we = 1'b0; b_we = 1'b0;
    a_addr = aa; b_addr = ba;
    tick();
    tick();
    $display("read %s a@%0d b@%0d", tag, aa, ba);
    check({tag, "_a"}, a_rdata, ea);
    check({tag, "_b"}, b_rdata, eb);
  endtask

  initial begin
    p55 = {64{8'h55}};
    paa = {64{8'haa}};
    px  = {16{32'hdeadbeef}};
    py  = {16{32'h12345678}};
    p11 = W'(8'h11);
    p22 = W'(8'h22);
    p01 = W'(8'h01);
    p02 = W'(8'h02);
    plo = {8{64'h0123456789abcdef}};
    phi = {8{64'hfedcba9876543210}};

    reset = 1'b0;
    a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_we = 1'b0; b_addr = '0; b_wdata = '0;
    #1;
    tick();
    tick();
    $display("reset applied");
    check("rst_a", a_rdata, '0);
    check("rst_b", b_rdata, '0);
    reset = 1'b1;

    // Simultaneous writes on both ports, then cross reads.
    wr(1'b1, 8'd3, p55, 1'b1, 8'd7, paa);
    rd("cross", 8'd7, 8'd3, paa, p55);

    // Swap two words in a single cycle.
    wr(1'b1, 8'd2, px, 1'b1, 8'd5, py);
    rd("swap_pre", 8'd2, 8'd5, px, py);
    wr(1'b1, 8'd2, py, 1'b1, 8'd5, px);
    rd("swap_post", 8'd2, 8'd5, py, px);

    // Read-first: A writes 0x22 to address 4 while both ports read address 4.
    wr(1'b1, 8'd4, p11, 1'b0, 8'd0, '0);
    a_we = 1'b1; a_addr = 8'd4; a_wdata = p22;
    b_we = 1'b0; b_addr = 8'd4;
    tick();                       // the write edge; the read register gets the old 0x11
    a_we = 1'b0;
    tick();                       // the old value reaches the outputs
    $display("read-first write a@4 read b@4");
    check("rf_old_b", b_rdata, p11);
    check("rf_old_a", a_rdata, p11);
    tick();                       // the read sampled one edge later returns the new value
    check("rf_new_b", b_rdata, p22);

    // Same-address write collision: port A must win.
    wr(1'b1, 8'd9, p01, 1'b1, 8'd9, p02);
    rd("collide", 8'd9, 8'd9, p01, p01);

    // Address range boundaries: no aliasing between word 0 and word 255.
    wr(1'b1, 8'd0, plo, 1'b1, 8'd255, phi);
    rd("bound_x", 8'd255, 8'd0, phi, plo);
    rd("bound_s", 8'd0, 8'd255, plo, phi);

`ifdef MRAM_INIT_ZERO_EN
    rd("unwritten", 8'd100, 8'd200, '0, '0);
`endif

    // Assert reset with a read in flight. A write attempted during reset must
    // be ignored.
    a_addr = 8'd3; b_addr = 8'd7;
    tick();                       // the read register now holds the old words
    reset = 1'b0;
    a_we = 1'b1; a_wdata = px;    // must not land while reset is low
    tick();
    a_we = 1'b0;
    $display("reset pulse mid-read");
    check("rst_mid_a", a_rdata, '0);
    check("rst_mid_b", b_rdata, '0);
    reset = 1'b1;
    tick();                       // first edge after release: address sampled, output still cleared
    check("rst_lat_a", a_rdata, '0);
    tick();
    $display("read after reset a@3 b@7");
    check("rst_keep_a", a_rdata, p55);
    check("rst_keep_b", b_rdata, paa);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
